serial_parity_checker: RTL and testbench

//   Receives a serial frame of DATA_BITS data bits (LSB first) plus one trailing parity bit.

---
 rtl/parity_pkg.sv | 13 +
 rtl/serial_parity_checker_if.sv | 24 ++
 rtl/parity_acc.sv | 21 ++
 rtl/serial_parity_checker.sv | 109 ++++++++++
 tb/tb_serial_parity_checker.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/parity_pkg.sv
// Shared state encodings and parity-sense constants for the serial parity checker.
package parity_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2
    } state_t;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

endpackage

// File: rtl/serial_parity_checker_if.sv
// Serial frame input and frame-status output bundle of the parity checker.
interface serial_parity_checker_if #(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned ERR_CNT_W = 8
);
    logic                 start;
    logic                 bit_in;
    logic                 bit_valid;
    logic                 busy;
    logic                 done;
    logic [DATA_BITS-1:0] data_out;
    logic                 parity_err;
    logic [ERR_CNT_W-1:0] err_count;

    modport master (
        output start, bit_in, bit_valid,
        input  busy, done, data_out, parity_err, err_count
    );

    modport slave (
        input  start, bit_in, bit_valid,
        output busy, done, data_out, parity_err, err_count
    );
endinterface

// File: rtl/parity_acc.sv
// 1-bit clocked XOR accumulator; clear has priority over enable.
module parity_acc (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 1'b0;
        end else if (clr) begin
            q <= 1'b0;
        end else if (en) begin
            q <= q ^ d;
        end
    end

endmodule

// File: rtl/serial_parity_checker.sv
// Deserialises an LSB-first frame plus trailing parity bit, flags parity mismatches and
// keeps a saturating count of failing frames.
module serial_parity_checker
    import parity_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned ODD_PARITY = 0,
    parameter int unsigned ERR_CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    serial_parity_checker_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);
    localparam logic PARITY_SENSE = (ODD_PARITY != 0) ? PARITY_ODD : PARITY_EVEN;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     bit_cnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 acc_q;
    logic                 done_q;
    logic                 parity_err_q;
    logic [DATA_BITS-1:0] data_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;

    logic take_bit;
    logic frame_end;
    logic frame_err;
    logic last_bit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // start overrides everything, including a bit offered in the same cycle
    always_comb begin
        state_d = state_q;
        if (bus.start) begin
            state_d = ST_DATA;
        end else begin
            case (state_q)
                ST_DATA:   if (bus.bit_valid && last_bit) state_d = ST_PARITY;
                ST_PARITY: if (bus.bit_valid) state_d = ST_IDLE;
                default:   state_d = state_q;
            endcase
        end
    end

    always_comb begin
        last_bit  = (bit_cnt_q == LAST_BIT);
        take_bit  = (state_q == ST_DATA) && bus.bit_valid && !bus.start;
        frame_end = (state_q == ST_PARITY) && bus.bit_valid && !bus.start;
        frame_err = (acc_q ^ bus.bit_in) != PARITY_SENSE;
    end

    parity_acc u_acc (
        .clk (clk),
        .rst (rst),
        .clr (bus.start),
        .en  (take_bit),
        .d   (bus.bit_in),
        .q   (acc_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_q <= '0;
            shift_q   <= '0;
        end else if (bus.start) begin
            bit_cnt_q <= '0;
            shift_q   <= '0;
        end else if (take_bit) begin
            bit_cnt_q <= last_bit ? '0 : bit_cnt_q + CNT_W'(1);
            shift_q   <= {bus.bit_in, shift_q[DATA_BITS-1:1]};
        end
    end

    // Result registers only move on a completed frame; aborts leave them untouched
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q       <= 1'b0;
            data_q       <= '0;
            parity_err_q <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            done_q <= frame_end;
            if (frame_end) begin
                data_q       <= shift_q;
                parity_err_q <= frame_err;
                if (frame_err && (err_cnt_q != '1)) begin
                    err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
                end
            end
        end
    end

    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.done       = done_q;
    assign bus.data_out   = data_q;
    assign bus.parity_err = parity_err_q;
    assign bus.err_count  = err_cnt_q;

endmodule

// File: tb/tb_serial_parity_checker.sv
// Scoreboard bench: three checkers (even/8-bit count, even/2-bit count, odd) share one stimulus.
module tb_serial_parity_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic bit_in = 1'b0;
    logic bit_valid = 1'b0;

    int n_tests = 0;
    int n_fail = 0;

    typedef struct {
        logic [7:0] data;
        logic       perr_even;
        logic       perr_odd;
        int         cnt0;
        int         cnt1;
        int         cnt2;
    } exp_t;

    exp_t sb[$];
    int   cnt0 = 0, cnt1 = 0, cnt2 = 0;

    always #5 clk = ~clk;

    serial_parity_checker_if #(.DATA_BITS(8), .ERR_CNT_W(8)) if0 ();
    serial_parity_checker_if #(.DATA_BITS(8), .ERR_CNT_W(2)) if1 ();
    serial_parity_checker_if #(.DATA_BITS(8), .ERR_CNT_W(8)) if2 ();

    assign if0.start = start;  assign if0.bit_in = bit_in;  assign if0.bit_valid = bit_valid;
    assign if1.start = start;  assign if1.bit_in = bit_in;  assign if1.bit_valid = bit_valid;
    assign if2.start = start;  assign if2.bit_in = bit_in;  assign if2.bit_valid = bit_valid;

    serial_parity_checker #(.DATA_BITS(8), .ODD_PARITY(0), .ERR_CNT_W(8)) u_even (
        .clk (clk), .rst (rst), .bus (if0)
    );
    serial_parity_checker #(.DATA_BITS(8), .ODD_PARITY(0), .ERR_CNT_W(2)) u_sat (
        .clk (clk), .rst (rst), .bus (if1)
    );
    serial_parity_checker #(.DATA_BITS(8), .ODD_PARITY(1), .ERR_CNT_W(8)) u_odd (
        .clk (clk), .rst (rst), .bus (if2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: one expected entry covering all three instances
    task automatic push_expected(input logic [7:0] data, input logic par);
        exp_t e;
        logic x;
        x = (^data) ^ par;
        if (x) begin
            cnt0 = (cnt0 < 255) ? cnt0 + 1 : 255;
            cnt1 = (cnt1 < 3) ? cnt1 + 1 : 3;
        end else begin
            cnt2 = (cnt2 < 255) ? cnt2 + 1 : 255;
        end
        e.data = data;
        e.perr_even = x;
        e.perr_odd = ~x;
        e.cnt0 = cnt0;
        e.cnt1 = cnt1;
        e.cnt2 = cnt2;
        sb.push_back(e);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic par, input int gap,
                              input bit junk);
        start = 1'b1;
        bit_valid = junk;
        bit_in = junk;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            for (int g = 0; g < gap; g++) begin
                bit_valid = 1'b0;
                tick();
                chk("busy_in_gap", {31'd0, if0.busy}, 32'd1);
            end
            bit_in = data[i];
            bit_valid = 1'b1;
            tick();
        end
        bit_in = par;
        bit_valid = 1'b1;
        push_expected(data, par);
        tick();
        bit_valid = 1'b0;
        chk("done_latency", {31'd0, if0.done}, 32'd1);
        chk("busy_at_done", {31'd0, if0.busy}, 32'd0);
        tick();
        chk("done_width", {31'd0, if0.done}, 32'd0);
    endtask

    // Monitor: pops one expectation per done pulse
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && (if0.done || if1.done || if2.done)) begin
                chk("done_aligned", {29'd0, if0.done, if1.done, if2.done}, 32'd7);
                chk("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("data_out", {24'd0, if0.data_out}, {24'd0, e.data});
                    chk("data_out_odd", {24'd0, if2.data_out}, {24'd0, e.data});
                    chk("perr_even", {31'd0, if0.parity_err}, {31'd0, e.perr_even});
                    chk("perr_sat", {31'd0, if1.parity_err}, {31'd0, e.perr_even});
                    chk("perr_odd", {31'd0, if2.parity_err}, {31'd0, e.perr_odd});
                    chk("err_count", {24'd0, if0.err_count}, e.cnt0);
                    chk("err_count_sat", {30'd0, if1.err_count}, e.cnt1);
                    chk("err_count_odd", {24'd0, if2.err_count}, e.cnt2);
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, {31'd0, if0.busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, if0.done}, 32'd0);
        chk({tag, "_data"}, {24'd0, if0.data_out}, 32'd0);
        chk({tag, "_perr"}, {31'd0, if0.parity_err}, 32'd0);
        chk({tag, "_cnt"}, {24'd0, if0.err_count}, 32'd0);
        chk({tag, "_cnt_sat"}, {30'd0, if1.err_count}, 32'd0);
    endtask

    initial begin
        logic [1:0] sat_exp [5];
        sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        #2;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // 1: good frame
        send_frame(8'hA5, 1'b0, 0, 1'b0);
        chk("t1_data", {24'd0, if0.data_out}, 32'h0000_00A5);
        chk("t1_perr", {31'd0, if0.parity_err}, 32'd0);
        chk("t1_cnt", {24'd0, if0.err_count}, 32'd0);

        // 2: bad frame then good zero frame
        send_frame(8'hA5, 1'b1, 0, 1'b0);
        chk("t2_perr", {31'd0, if0.parity_err}, 32'd1);
        chk("t2_cnt", {24'd0, if0.err_count}, 32'd1);
        send_frame(8'h00, 1'b0, 0, 1'b0);
        chk("t2b_perr", {31'd0, if0.parity_err}, 32'd0);
        chk("t2b_cnt", {24'd0, if0.err_count}, 32'd1);

        // 3: gaps between bits
        send_frame(8'h3C, 1'b0, 5, 1'b0);
        chk("t3_data", {24'd0, if0.data_out}, 32'h0000_003C);
        chk("t3_perr", {31'd0, if0.parity_err}, 32'd0);

        // 4: abort after four bits, restart with a bit offered alongside start
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t4_hold_on_start", {24'd0, if0.data_out}, 32'h0000_003C);
        for (int i = 0; i < 4; i++) begin
            bit_in = 1'b1;
            bit_valid = 1'b1;
            tick();
        end
        send_frame(8'hFF, 1'b0, 0, 1'b1);
        chk("t4_data", {24'd0, if0.data_out}, 32'h0000_00FF);
        chk("t4_perr", {31'd0, if0.parity_err}, 32'd0);
        chk("t4_cnt", {24'd0, if0.err_count}, 32'd1);

        // 4b: reset mid-frame
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bit_in = 1'b1;
            bit_valid = 1'b1;
            tick();
        end
        bit_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        cnt0 = 0;
        cnt1 = 0;
        cnt2 = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();
        tick();
        chk("midrst_busy_after", {31'd0, if0.busy}, 32'd0);

        // 5: saturation of the 2-bit counter
        for (int i = 0; i < 5; i++) begin
            send_frame(8'hA5, 1'b1, 0, 1'b0);
            chk("t5_sat_cnt", {30'd0, if1.err_count}, {30'd0, sat_exp[i]});
            chk("t5_sat_perr", {31'd0, if1.parity_err}, 32'd1);
        end

        // 6: odd-parity instance
        send_frame(8'hA5, 1'b1, 0, 1'b0);
        chk("t6_odd_good", {31'd0, if2.parity_err}, 32'd0);
        send_frame(8'hA5, 1'b0, 0, 1'b0);
        chk("t6_odd_bad", {31'd0, if2.parity_err}, 32'd1);

        repeat (3) tick();
        chk("sb_drain", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
